ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pipe.sv | 106 ++++++++++
 tb/tb_ctrl_pipe.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control-payload pipeline after decode with per-stage
// stall/flush, bubble-event counter and sticky illegal-stall flag.
module ctrl_pipe #(
  parameter int W         = 16,
  parameter int STAGES    = 3,
  parameter int LAST_HOLD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W-1:0]          in_data,
  input  logic                  in_valid,
  input  logic [STAGES-1:0]     stall,
  input  logic [STAGES-1:0]     flush,
  input  logic                  flush_all,
  input  logic                  cnt_clr,
  output logic [STAGES*W-1:0]   stage_data,
  output logic [STAGES-1:0]     stage_valid,
  output logic [15:0]           bubble_cnt,
  output logic                  stall_err
);

  logic [STAGES-1:0][W-1:0] data_q, data_d, up_data;
  logic [STAGES-1:0]        valid_q, valid_d, up_valid;
  logic [STAGES-1:0]        up_stall, es, bub;
  logic [15:0]              cnt_q, cnt_d;
  logic                     err_q, err_d;

  always_comb begin
    es = stall;
    if (LAST_HOLD == 0) es[STAGES-1] = 1'b0;
  end

  // Stage 0 is fed from decode; bubbles always carry a zero payload.
  always_comb begin
    up_data     = '0;
    up_valid    = '0;
    up_stall    = '0;
    up_data[0]  = in_valid ? in_data : '0;
    up_valid[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      up_data[k]  = data_q[k-1];
      up_valid[k] = valid_q[k-1];
      up_stall[k] = es[k-1];
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    bub     = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (flush_all || flush[k]) begin
        data_d[k]  = '0;
        valid_d[k] = 1'b0;
      end else if (es[k]) begin
        data_d[k]  = data_q[k];
        valid_d[k] = valid_q[k];
      end else if (up_stall[k]) begin
        data_d[k]  = '0;
        valid_d[k] = 1'b0;
        bub[k]     = 1'b1;
      end else begin
        data_d[k]  = up_data[k];
        valid_d[k] = up_valid[k];
      end
    end
  end

  // A stalled stage behind an advancing valid stage loses that instruction.
  always_comb begin
    err_d = err_q;
    for (int k = 1; k < STAGES; k++) begin
      if (es[k] && !es[k-1] && valid_q[k-1] &&
          !flush_all && !flush[k-1])
        err_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)
      cnt_d = '0;
    else if ((|bub) && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign stage_data  = data_q;
  assign stage_valid = valid_q;
  assign bubble_cnt  = cnt_q;
  assign stall_err   = err_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed checks of ctrl_pipe with LAST_HOLD=0 (dut0)
// and LAST_HOLD=1 (dut1) driven from the same stimulus.
module tb_ctrl_pipe;

  localparam int W = 16;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic [S-1:0] stall = '0;
  logic [S-1:0] flush = '0;
  logic         flush_all = 1'b0;
  logic         cnt_clr = 1'b0;

  logic [S*W-1:0] sd0, sd1;
  logic [S-1:0]   sv0, sv1;
  logic [15:0]    bc0, bc1;
  logic           se0, se1;

  int total = 0;
  int bad = 0;

  localparam logic [15:0] A = 16'hAAA1;
  localparam logic [15:0] B = 16'hBBB2;
  localparam logic [15:0] C = 16'hCCC3;
  localparam logic [15:0] D = 16'hDDD4;

  ctrl_pipe #(.W(W), .STAGES(S), .LAST_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .stall(stall), .flush(flush), .flush_all(flush_all),
    .cnt_clr(cnt_clr), .stage_data(sd0), .stage_valid(sv0),
    .bubble_cnt(bc0), .stall_err(se0)
  );

  ctrl_pipe #(.W(W), .STAGES(S), .LAST_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .stall(stall), .flush(flush), .flush_all(flush_all),
    .cnt_clr(cnt_clr), .stage_data(sd1), .stage_valid(sv1),
    .bubble_cnt(bc1), .stall_err(se1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_data = '0; in_valid = 1'b0; stall = '0; flush = '0;
    flush_all = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // After three edges: stage2=C, stage1=B, stage0=A.
  task automatic fill();
    in_valid = 1'b1;
    in_data = C; step();
    in_data = B; step();
    in_data = A; step();
    in_valid = 1'b0; in_data = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #3;
    total++;
    if ({sd0, sv0, bc0, se0, sd1, sv1, bc1, se1} !== '0) begin
      bad++;
      $display("FAIL reset got=%h/%h/%h/%b exp=0", sd0, sv0, bc0, se0);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_latency();
    logic [47:0] ed [3];
    logic [2:0]  ev [3];
    do_reset();
    ed[0] = {16'h0, 16'h0, 16'h1234}; ev[0] = 3'b001;
    ed[1] = {16'h0, 16'h1234, 16'h0}; ev[1] = 3'b010;
    ed[2] = {16'h1234, 16'h0, 16'h0}; ev[2] = 3'b100;
    in_data = 16'h1234; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      in_valid = 1'b0; in_data = 16'h5555;
      total++;
      if (sd0 !== ed[i] || sv0 !== ev[i]) begin
        bad++;
        $display("FAIL latency%0d got=%h/%b exp=%h/%b",
                 i, sd0, sv0, ed[i], ev[i]);
      end
    end
    total++;
    if (bc0 !== 16'd0) begin
      bad++;
      $display("FAIL latency_cnt got=%h exp=0", bc0);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill();
    total++;
    if (sd0 !== {C, B, A} || sv0 !== 3'b111) begin
      bad++;
      $display("FAIL b2b got=%h/%b exp=%h/111", sd0, sv0, {C, B, A});
    end
    step();
    total++;
    if (sd0 !== {B, A, 16'h0} || sv0 !== 3'b110) begin
      bad++;
      $display("FAIL b2b_drain got=%h/%b exp=%h/110",
               sd0, sv0, {B, A, 16'h0});
    end
  endtask

  task automatic test_stall();
    do_reset();
    fill();
    stall = 3'b011;
    in_data = D; in_valid = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      step();
      total++;
      if (sd0 !== {16'h0, B, A} || sv0 !== 3'b011) begin
        bad++;
        $display("FAIL stall%0d got=%h/%b exp=%h/011",
                 i, sd0, sv0, {16'h0, B, A});
      end
      total++;
      if (bc0 !== 16'(i)) begin
        bad++;
        $display("FAIL stall_cnt%0d got=%h exp=%h", i, bc0, 16'(i));
      end
    end
    total++;
    if (se0 !== 1'b0) begin
      bad++;
      $display("FAIL stall_noerr got=%b exp=0", se0);
    end
    // bit 2 is ignored in dut0: stage 2 keeps taking bubbles
    stall = 3'b111;
    step();
    total++;
    if (sv0 !== 3'b011 || bc0 !== 16'd3) begin
      bad++;
      $display("FAIL stall_bit2 got=%b/%h exp=011/0003", sv0, bc0);
    end
  endtask

  task automatic test_last_hold();
    do_reset();
    fill();
    stall = 3'b100;
    in_data = D; in_valid = 1'b1;
    step();
    idle();
    total++;
    if (sd1 !== {C, A, D} || sv1 !== 3'b111) begin
      bad++;
      $display("FAIL lasthold got=%h/%b exp=%h/111", sd1, sv1, {C, A, D});
    end
    total++;
    if (se1 !== 1'b1) begin
      bad++;
      $display("FAIL lasthold_err got=%b exp=1", se1);
    end
    total++;
    if (se0 !== 1'b0 || sd0 !== {B, A, D}) begin
      bad++;
      $display("FAIL lasthold_dut0 got=%b/%h exp=0/%h", se0, sd0, {B, A, D});
    end
    cnt_clr = 1'b1; step();
    cnt_clr = 1'b0; flush_all = 1'b1; step();
    flush_all = 1'b0; flush = 3'b111; step();
    idle();
    total++;
    if (se1 !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky got=%b exp=1", se1);
    end
  endtask

  task automatic test_flush();
    do_reset();
    fill();
    stall = 3'b111; flush = 3'b010;
    in_data = D; in_valid = 1'b1;
    step();
    total++;
    if (sd1 !== {C, 16'h0, A} || sv1 !== 3'b101) begin
      bad++;
      $display("FAIL flush got=%h/%b exp=%h/101", sd1, sv1, {C, 16'h0, A});
    end
    total++;
    if (se1 !== 1'b0 || bc1 !== 16'd0) begin
      bad++;
      $display("FAIL flush_side got=%b/%h exp=0/0000", se1, bc1);
    end
    flush = '0; flush_all = 1'b1;
    step();
    idle();
    total++;
    if (sd1 !== '0 || sv1 !== '0 || sd0 !== '0 || sv0 !== '0) begin
      bad++;
      $display("FAIL flush_all got=%h/%b %h/%b exp=0", sd1, sv1, sd0, sv0);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    stall = 3'b001;
    repeat (65534) step();
    total++;
    if (bc0 !== 16'hFFFE) begin
      bad++;
      $display("FAIL sat_fffe got=%h exp=fffe", bc0);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bc0 !== 16'hFFFF) begin
        bad++;
        $display("FAIL sat_hold%0d got=%h exp=ffff", i, bc0);
      end
    end
    cnt_clr = 1'b1;
    step();
    idle();
    total++;
    if (bc0 !== 16'h0) begin
      bad++;
      $display("FAIL sat_clr got=%h exp=0", bc0);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    fill();
    stall = 3'b011;
    step();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({sd0, sv0, bc0, se0} !== '0) begin
      bad++;
      $display("FAIL arst got=%h/%b/%h/%b exp=0", sd0, sv0, bc0, se0);
    end
    #1;
    rst = 1'b0;
    idle();
    in_data = D; in_valid = 1'b1;
    step();
    idle();
    total++;
    if (sd0 !== {16'h0, 16'h0, D} || sv0 !== 3'b001) begin
      bad++;
      $display("FAIL arst_after got=%h/%b exp=%h/001",
               sd0, sv0, {16'h0, 16'h0, D});
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_stall();
    test_last_hold();
    test_flush();
    test_saturate();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
